// File: rtl/issue_queue_pkg.sv
// ---------------------------------------------------------------------------
// issue_queue_pkg
// Shared configuration for the issue queue slice: default sizes and the
// per-entry storage record. The top module's PHY_W / PAYLOAD_W parameters
// default to the widths used here; the entry record is sized from these
// package widths, so instances must keep PHY_W == IQ_PHY_W and
// PAYLOAD_W == IQ_PAYLOAD_W.
// ---------------------------------------------------------------------------
package issue_queue_pkg;

  localparam int IQ_DEPTH          = 16;
  localparam int IQ_DISPATCH_WIDTH = 2;
  localparam int IQ_ISSUE_WIDTH    = 2;
  localparam int IQ_WAKEUP_NUM     = 4;
  localparam int IQ_PHY_W          = 6;
  localparam int IQ_PAYLOAD_W      = 64;

  // One queue slot: occupancy, operand readiness, register ids and payload.
  typedef struct packed {
    logic                    valid;
    logic                    src1Ready;
    logic                    src2Ready;
    logic [IQ_PHY_W-1:0]     src1Phy;
    logic [IQ_PHY_W-1:0]     src2Phy;
    logic [IQ_PHY_W-1:0]     rdPhy;
    logic [IQ_PAYLOAD_W-1:0] payload;
  } iq_entry_t;

endpackage

// File: rtl/issue_queue_select.sv
// ---------------------------------------------------------------------------
// issue_queue_select
// Combinational first-K picker: reports the indices of the K lowest-index
// set bits of req_i, lowest first. Used both to find free slots for
// dispatch and to pick eligible entries for issue.
// Ports:
//   req_i        N-bit request vector
//   grantValid_o per-grant valid (grant k exists when req_i has > k set bits)
//   grantIdx_o   index of the k-th lowest set bit
// ---------------------------------------------------------------------------
module issue_queue_select #(
  parameter  int N     = 16,
  parameter  int K     = 2,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]            req_i,
  output logic [K-1:0]            grantValid_o,
  output logic [K-1:0][IDX_W-1:0] grantIdx_o
);

  int found;

  // Walk upward, handing each set bit to the next unfilled grant slot.
  always_comb begin
    grantValid_o = '0;
    grantIdx_o   = '0;
    found        = 0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        for (int k = 0; k < K; k++) begin
          if (found == k) begin
            grantValid_o[k] = 1'b1;
            grantIdx_o[k]   = IDX_W'(i);
          end
        end
        found = found + 1;
      end
    end
  end

endmodule

// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
// Out-of-order issue queue. Accepts up to DISPATCH_WIDTH instructions per
// cycle (all-or-nothing) into the lowest free slots, tracks operand
// readiness through wakeup broadcasts (with same-cycle bypass at dispatch),
// and issues up to ISSUE_WIDTH ready entries per cycle, oldest-slot-first
// by index, under a valid/ready handshake.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   flush_i              drop every entry, block dispatch and issue
//   dispatch_*_i         per-lane dispatch request and operands
//   dispatch_ready_o     all lanes can be accepted this cycle
//   wakeup_valid_i/phy   result broadcast channels
//   issue_valid_o/ready  issue handshake per port, with rd id and payload
//   free_count_o         registered number of empty slots
//   queue_full_add_o     registered pulse: dispatch was blocked last cycle
// ---------------------------------------------------------------------------
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH          = IQ_DEPTH,
  parameter int DISPATCH_WIDTH = IQ_DISPATCH_WIDTH,
  parameter int ISSUE_WIDTH    = IQ_ISSUE_WIDTH,
  parameter int WAKEUP_NUM     = IQ_WAKEUP_NUM,
  parameter int PHY_W          = IQ_PHY_W,
  parameter int PAYLOAD_W      = IQ_PAYLOAD_W
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     flush_i,
  input  logic [DISPATCH_WIDTH-1:0]                dispatch_valid_i,
  input  logic [DISPATCH_WIDTH-1:0][PHY_W-1:0]     dispatch_src1_phy_i,
  input  logic [DISPATCH_WIDTH-1:0][PHY_W-1:0]     dispatch_src2_phy_i,
  input  logic [DISPATCH_WIDTH-1:0]                dispatch_src1_ready_i,
  input  logic [DISPATCH_WIDTH-1:0]                dispatch_src2_ready_i,
  input  logic [DISPATCH_WIDTH-1:0][PHY_W-1:0]     dispatch_rd_phy_i,
  input  logic [DISPATCH_WIDTH-1:0][PAYLOAD_W-1:0] dispatch_payload_i,
  output logic                                     dispatch_ready_o,
  input  logic [WAKEUP_NUM-1:0]                    wakeup_valid_i,
  input  logic [WAKEUP_NUM-1:0][PHY_W-1:0]         wakeup_phy_id_i,
  output logic [ISSUE_WIDTH-1:0]                   issue_valid_o,
  input  logic [ISSUE_WIDTH-1:0]                   issue_ready_i,
  output logic [ISSUE_WIDTH-1:0][PHY_W-1:0]        issue_rd_phy_o,
  output logic [ISSUE_WIDTH-1:0][PAYLOAD_W-1:0]    issue_payload_o,
  output logic [$clog2(DEPTH):0]                   free_count_o,
  output logic                                     queue_full_add_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t                            entries_q [DEPTH];
  iq_entry_t                            entries_d [DEPTH];
  iq_entry_t                            laneEntry [DISPATCH_WIDTH];
  logic      [CNT_W-1:0]                freeCount_q, freeCount_d;
  logic                                 fullPulse_q, fullPulse_d;
  logic      [DEPTH-1:0]                freeVec, eligibleVec;
  logic      [DISPATCH_WIDTH-1:0]       allocValid;
  logic      [DISPATCH_WIDTH-1:0][IDX_W-1:0] allocIdx;
  logic      [ISSUE_WIDTH-1:0]          issueGrant;
  logic      [ISSUE_WIDTH-1:0][IDX_W-1:0]    issueIdx;
  int                                   laneSlot;
  int                                   issueCnt;

  // True when any live wakeup channel broadcasts this physical id.
  function automatic logic wakeHit(input logic [WAKEUP_NUM-1:0]            v,
                                   input logic [WAKEUP_NUM-1:0][PHY_W-1:0] ids,
                                   input logic [PHY_W-1:0]                 phy);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WAKEUP_NUM; w++) begin
      if (v[w] && (ids[w] == phy)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Free and eligible views are built from registered state only, so a
  // slot freed by issue this cycle is never handed to dispatch, and a
  // freshly written entry cannot be selected before the next cycle.
  always_comb begin
    freeVec     = '0;
    eligibleVec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      freeVec[i]     = !entries_q[i].valid;
      eligibleVec[i] = entries_q[i].valid && entries_q[i].src1Ready &&
                       entries_q[i].src2Ready;
    end
  end

  issue_queue_select #(.N(DEPTH), .K(DISPATCH_WIDTH)) allocSel (
    .req_i        (freeVec),
    .grantValid_o (allocValid),
    .grantIdx_o   (allocIdx)
  );

  issue_queue_select #(.N(DEPTH), .K(ISSUE_WIDTH)) issueSel (
    .req_i        (eligibleVec),
    .grantValid_o (issueGrant),
    .grantIdx_o   (issueIdx)
  );

  assign dispatch_ready_o = (freeCount_q >= CNT_W'(DISPATCH_WIDTH)) && !flush_i;
  assign issue_valid_o    = issueGrant & {ISSUE_WIDTH{!flush_i}};
  assign free_count_o     = freeCount_q;
  assign queue_full_add_o = fullPulse_q;

  // Issue ports read straight out of the selected slots.
  always_comb begin
    issue_rd_phy_o  = '0;
    issue_payload_o = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      issue_rd_phy_o[k]  = entries_q[issueIdx[k]].rdPhy;
      issue_payload_o[k] = entries_q[issueIdx[k]].payload;
    end
  end

  // Candidate entry per dispatch lane, with operands that are woken in
  // the same cycle captured as already ready.
  always_comb begin
    for (int l = 0; l < DISPATCH_WIDTH; l++) begin
      laneEntry[l].valid     = 1'b1;
      laneEntry[l].src1Ready = dispatch_src1_ready_i[l] ||
                               wakeHit(wakeup_valid_i, wakeup_phy_id_i, dispatch_src1_phy_i[l]);
      laneEntry[l].src2Ready = dispatch_src2_ready_i[l] ||
                               wakeHit(wakeup_valid_i, wakeup_phy_id_i, dispatch_src2_phy_i[l]);
      laneEntry[l].src1Phy   = dispatch_src1_phy_i[l];
      laneEntry[l].src2Phy   = dispatch_src2_phy_i[l];
      laneEntry[l].rdPhy     = dispatch_rd_phy_i[l];
      laneEntry[l].payload   = dispatch_payload_i[l];
    end
  end

  // Next queue contents: wakeups, issue departures and dispatch writes.
  // Valid lanes are packed into free slots in lane order, so the first
  // valid lane lands in the lowest free slot.
  always_comb begin
    entries_d = entries_q;
    laneSlot  = 0;
    issueCnt  = 0;
    if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].valid) begin
          if (wakeHit(wakeup_valid_i, wakeup_phy_id_i, entries_q[i].src1Phy))
            entries_d[i].src1Ready = 1'b1;
          if (wakeHit(wakeup_valid_i, wakeup_phy_id_i, entries_q[i].src2Phy))
            entries_d[i].src2Ready = 1'b1;
        end
      end
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
        if (issue_valid_o[k] && issue_ready_i[k]) begin
          entries_d[issueIdx[k]].valid = 1'b0;
          issueCnt = issueCnt + 1;
        end
      end
      if (dispatch_ready_o) begin
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
          if (dispatch_valid_i[l]) begin
            for (int s = 0; s < DISPATCH_WIDTH; s++) begin
              if ((laneSlot == s) && allocValid[s]) entries_d[allocIdx[s]] = laneEntry[l];
            end
            laneSlot = laneSlot + 1;
          end
        end
      end
    end
  end

  // Free count and the blocked-dispatch pulse for the next cycle.
  always_comb begin
    if (flush_i) begin
      freeCount_d = CNT_W'(DEPTH);
    end else begin
      freeCount_d = freeCount_q + CNT_W'(issueCnt) - CNT_W'(laneSlot);
    end
    fullPulse_d = (|dispatch_valid_i) && !dispatch_ready_o && !flush_i;
  end

  // State registers; reset empties the queue immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      freeCount_q <= CNT_W'(DEPTH);
      fullPulse_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
      freeCount_q <= freeCount_d;
      fullPulse_q <= fullPulse_d;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// ---------------------------------------------------------------------------
// tb_issue_queue
// Drives directed scenarios and randomized traffic into issue_queue and
// compares every cycle against a slot-array reference model built from the
// queue's behavioural rules.
// ---------------------------------------------------------------------------
module tb_issue_queue;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic [1:0]       dv;
  logic [1:0][5:0]  s1, s2, rd;
  logic [1:0]       r1, r2;
  logic [1:0][63:0] pay;
  logic [3:0]       wv;
  logic [3:0][5:0]  wid;
  logic [1:0]       ir;
  logic             dReady;
  logic [1:0]       iValid;
  logic [1:0][5:0]  iRd;
  logic [1:0][63:0] iPay;
  logic [4:0]       freeCnt;
  logic             fullAdd;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: one record per slot.
  bit          mValid [16];
  bit          mR1    [16];
  bit          mR2    [16];
  logic [5:0]  mS1    [16];
  logic [5:0]  mS2    [16];
  logic [5:0]  mRd    [16];
  logic [63:0] mPay   [16];
  bit          mFull;

  always #5 clk = ~clk;

  issue_queue dut (
    .clk_i                 (clk),
    .rst_ni                (rstN),
    .flush_i               (flush),
    .dispatch_valid_i      (dv),
    .dispatch_src1_phy_i   (s1),
    .dispatch_src2_phy_i   (s2),
    .dispatch_src1_ready_i (r1),
    .dispatch_src2_ready_i (r2),
    .dispatch_rd_phy_i     (rd),
    .dispatch_payload_i    (pay),
    .dispatch_ready_o      (dReady),
    .wakeup_valid_i        (wv),
    .wakeup_phy_id_i       (wid),
    .issue_valid_o         (iValid),
    .issue_ready_i         (ir),
    .issue_rd_phy_o        (iRd),
    .issue_payload_o       (iPay),
    .free_count_o          (freeCnt),
    .queue_full_add_o      (fullAdd)
  );

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      mValid[i] = 0; mR1[i] = 0; mR2[i] = 0;
    end
    mFull = 0;
  endtask

  function automatic bit woke(input logic [5:0] id);
    for (int w = 0; w < 4; w++) if (wv[w] && wid[w] == id) return 1;
    return 0;
  endfunction

  // Quiet inputs; issue side accepts everything.
  task automatic setIdle();
    flush = 0; dv = '0; s1 = '0; s2 = '0; r1 = '0; r2 = '0;
    rd = '0; pay = '0; wv = '0; wid = '0; ir = 2'b11;
  endtask

  task automatic setLane(input int l, input logic [5:0] a, input bit ra,
                         input logic [5:0] b, input bit rb, input logic [5:0] d);
    dv[l] = 1'b1; s1[l] = a; r1[l] = ra; s2[l] = b; r2[l] = rb; rd[l] = d;
    pay[l] = {$urandom, $urandom};
  endtask

  // Random traffic; ids drawn from a small range so wakeups hit often.
  task automatic applyStimulus(input int irPct, input int flushPct);
    flush = ($urandom_range(0, 99) < flushPct);
    dv    = 2'($urandom);
    for (int l = 0; l < 2; l++) begin
      s1[l]  = 6'($urandom_range(0, 15));
      s2[l]  = 6'($urandom_range(0, 15));
      r1[l]  = ($urandom_range(0, 99) < 40);
      r2[l]  = ($urandom_range(0, 99) < 40);
      rd[l]  = 6'($urandom);
      pay[l] = {$urandom, $urandom};
      ir[l]  = ($urandom_range(0, 99) < irPct);
    end
    for (int w = 0; w < 4; w++) begin
      wv[w]  = ($urandom_range(0, 99) < 30);
      wid[w] = 6'($urandom_range(0, 15));
    end
    #1;
  endtask

  // Compare this cycle's outputs with the model, advance the model by the
  // queue rules, then move to the next falling edge.
  task automatic stepCycle();
    int  freeN;
    bit  expReady;
    int  expIdx [2];
    bit  expValid [2];
    int  n;
    bit  wasValid [16];
    int  nextFree;
    freeN = 0;
    for (int i = 0; i < 16; i++) if (!mValid[i]) freeN++;
    expReady = (freeN >= 2) && !flush;
    n = 0;
    for (int k = 0; k < 2; k++) begin expIdx[k] = 0; expValid[k] = 0; end
    for (int i = 0; i < 16; i++) begin
      if (mValid[i] && mR1[i] && mR2[i] && n < 2) begin
        expIdx[n] = i; expValid[n] = !flush; n++;
      end
    end
    checkOutput("free_count", 64'(freeCnt), 64'(freeN));
    checkOutput("dispatch_ready", 64'(dReady), 64'(expReady));
    checkOutput("queue_full_add", 64'(fullAdd), 64'(mFull));
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("issue_valid[%0d]", k), 64'(iValid[k]), 64'(expValid[k]));
      if (expValid[k]) begin
        checkOutput($sformatf("issue_rd_phy[%0d]", k), 64'(iRd[k]), 64'(mRd[expIdx[k]]));
        checkOutput($sformatf("issue_payload[%0d]", k), iPay[k], mPay[expIdx[k]]);
      end
    end
    wasValid = mValid;
    if (flush) begin
      modelReset();
    end else begin
      mFull = (dv != 0) && !expReady;
      for (int i = 0; i < 16; i++) begin
        if (mValid[i]) begin
          if (woke(mS1[i])) mR1[i] = 1;
          if (woke(mS2[i])) mR2[i] = 1;
        end
      end
      for (int k = 0; k < 2; k++) if (expValid[k] && ir[k]) mValid[expIdx[k]] = 0;
      if (expReady) begin
        nextFree = 0;
        for (int l = 0; l < 2; l++) begin
          if (dv[l]) begin
            while (wasValid[nextFree]) nextFree++;
            mValid[nextFree] = 1;
            mR1[nextFree]    = r1[l] || woke(s1[l]);
            mR2[nextFree]    = r2[l] || woke(s2[l]);
            mS1[nextFree]    = s1[l];
            mS2[nextFree]    = s2[l];
            mRd[nextFree]    = rd[l];
            mPay[nextFree]   = pay[l];
            nextFree++;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rstN = 1'b0;
    setIdle();
    modelReset();
    #12;
    checkOutput("rst_free_count", 64'(freeCnt), 64'd16);
    checkOutput("rst_dispatch_ready", 64'(dReady), 64'd1);
    checkOutput("rst_issue_valid", 64'(iValid), 64'd0);
    checkOutput("rst_queue_full_add", 64'(fullAdd), 64'd0);
    #1 rstN = 1'b1;
    @(negedge clk);

    // Two ready instructions issue together the following cycle.
    setIdle(); setLane(0, 6'd1, 1, 6'd2, 1, 6'd3); setLane(1, 6'd1, 1, 6'd2, 1, 6'd4); #1;
    stepCycle();
    setIdle(); #1;
    checkOutput("dual_issue_valid", 64'(iValid), 64'd3);
    checkOutput("dual_issue_rd0", 64'(iRd[0]), 64'd3);
    checkOutput("dual_issue_rd1", 64'(iRd[1]), 64'd4);
    stepCycle();
    setIdle(); #1;
    checkOutput("dual_issue_free", 64'(freeCnt), 64'd16);
    stepCycle();

    // Wakeup two cycles after dispatch; issue exactly one cycle later.
    setIdle(); setLane(0, 6'd5, 0, 6'd7, 1, 6'd11); #1;
    stepCycle();
    setIdle(); #1;
    stepCycle();
    setIdle(); wv[0] = 1'b1; wid[0] = 6'd5; #1;
    checkOutput("wake_not_yet", 64'(iValid[0]), 64'd0);
    stepCycle();
    setIdle(); #1;
    checkOutput("wake_issue", 64'(iValid[0]), 64'd1);
    checkOutput("wake_issue_rd", 64'(iRd[0]), 64'd11);
    stepCycle();

    // Same-cycle wakeup bypass at dispatch (phy 0 on the other source).
    setIdle(); setLane(0, 6'd0, 1, 6'd9, 0, 6'd12); wv[2] = 1'b1; wid[2] = 6'd9; #1;
    stepCycle();
    setIdle(); #1;
    checkOutput("bypass_issue", 64'(iValid[0]), 64'd1);
    stepCycle();

    // Fill all 16 slots with unready work, then push once more.
    for (int c = 0; c < 8; c++) begin
      setIdle(); ir = 2'b00;
      setLane(0, (c == 0) ? 6'd30 : 6'd20, 0, 6'd21, (c == 0), 6'd40 + 6'(c));
      setLane(1, 6'd20, 0, 6'd21, 0, 6'd50);
      #1;
      stepCycle();
    end
    setIdle(); ir = 2'b00; setLane(0, 6'd1, 1, 6'd1, 1, 6'd1); setLane(1, 6'd1, 1, 6'd1, 1, 6'd1); #1;
    checkOutput("full_dispatch_ready", 64'(dReady), 64'd0);
    checkOutput("full_free_count", 64'(freeCnt), 64'd0);
    stepCycle();
    setIdle(); ir = 2'b00; wv[1] = 1'b1; wid[1] = 6'd30; #1;
    checkOutput("full_pulse", 64'(fullAdd), 64'd1);
    stepCycle();
    for (int c = 0; c < 2; c++) begin
      setIdle(); ir = 2'b00; #1;
      checkOutput("held_issue_valid", 64'(iValid[0]), 64'd1);
      checkOutput("held_issue_rd", 64'(iRd[0]), 64'd40);
      stepCycle();
    end
    setIdle(); flush = 1'b1; #1;
    stepCycle();

    // Flush with seven entries (one eligible) and a simultaneous dispatch.
    for (int c = 0; c < 4; c++) begin
      setIdle(); ir = 2'b00;
      setLane(0, 6'd20, (c == 0), 6'd21, (c == 0), 6'd60 + 6'(c));
      if (c < 3) setLane(1, 6'd20, 0, 6'd21, 0, 6'd61);
      #1;
      stepCycle();
    end
    setIdle(); flush = 1'b1; ir = 2'b11;
    setLane(0, 6'd1, 1, 6'd1, 1, 6'd2); setLane(1, 6'd1, 1, 6'd1, 1, 6'd3); #1;
    checkOutput("flush_pre_free", 64'(freeCnt), 64'd9);
    checkOutput("flush_issue_valid", 64'(iValid), 64'd0);
    stepCycle();
    for (int c = 0; c < 3; c++) begin
      setIdle(); wv = 4'hf; wid = {6'd20, 6'd21, 6'd20, 6'd21}; #1;
      checkOutput("post_flush_free", 64'(freeCnt), 64'd16);
      checkOutput("post_flush_issue", 64'(iValid), 64'd0);
      stepCycle();
    end

    // Randomized traffic under different back-pressure levels.
    for (int c = 0; c < 700; c++) begin applyStimulus(90, 2); stepCycle(); end
    for (int c = 0; c < 700; c++) begin applyStimulus(25, 2); stepCycle(); end
    for (int c = 0; c < 700; c++) begin applyStimulus(65, 1); stepCycle(); end

    // Asynchronous reset in the middle of a cycle.
    setIdle(); ir = 2'b00; setLane(0, 6'd1, 1, 6'd1, 1, 6'd1); #1;
    stepCycle();
    setIdle(); ir = 2'b00; #1;
    #1 rstN = 1'b0;
    #1;
    checkOutput("async_rst_free", 64'(freeCnt), 64'd16);
    checkOutput("async_rst_issue", 64'(iValid), 64'd0);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    for (int c = 0; c < 50; c++) begin applyStimulus(70, 0); stepCycle(); end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
